// File: rtl/combo_lock_ctrl.sv
// combo_lock_ctrl: keypad combination lock with programmable code,
// wrong-entry counting and a timed alarm lockout.
module combo_lock_ctrl #(
  parameter int                 DIGITS       = 4,
  parameter int                 MAX_FAIL     = 3,
  parameter int                 LOCK_CYCLES  = 16,
  parameter logic [2*DIGITS-1:0] DEFAULT_CODE = {2'd3, 2'd2, 2'd1, 2'd0}
) (
  input  logic       Clk,
  input  logic       Resetn,
  input  logic [3:0] Btn,
  input  logic       Set,
  input  logic       Lock,
  output logic       Unlocked,
  output logic       Prog,
  output logic       Alarm,
  output logic [2:0] Count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OPEN,
    S_PROG,
    S_LOCKOUT
  } state_t;

  localparam logic [2:0]  LAST_IDX = 3'(DIGITS - 1);
  localparam logic [3:0]  FAIL_LIM = 4'(MAX_FAIL);
  localparam logic [15:0] LOCK_LD  = 16'(LOCK_CYCLES - 1);

  state_t                r_state;
  logic [2*DIGITS-1:0]   r_code;
  logic [2*DIGITS-1:0]   r_shadow;
  logic [3:0]            r_fail;
  logic [2:0]            r_cnt;
  logic                  r_mis;
  logic [15:0]           r_lcnt;

  state_t                w_state_n;
  logic [2*DIGITS-1:0]   w_code_n;
  logic [2*DIGITS-1:0]   w_shadow_n;
  logic [2*DIGITS-1:0]   w_shadow_wr;
  logic [3:0]            w_fail_n;
  logic [3:0]            w_fail_inc;
  logic [2:0]            w_cnt_n;
  logic                  w_mis_n;
  logic                  w_mis_acc;
  logic [15:0]           w_lcnt_n;

  logic                  w_press;
  logic                  w_valid;
  logic [1:0]            w_digit;
  logic [1:0]            w_code_dig;
  logic                  w_last;

  assign w_press    = |Btn;
  assign w_last     = (r_cnt == LAST_IDX);
  assign w_fail_inc = r_fail + 4'd1;

  // One-hot decode; anything with more than one bit is an invalid press.
  always_comb begin
    w_valid = 1'b0;
    w_digit = 2'd0;
    unique case (Btn)
      4'b0001: begin w_valid = 1'b1; w_digit = 2'd0; end
      4'b0010: begin w_valid = 1'b1; w_digit = 2'd1; end
      4'b0100: begin w_valid = 1'b1; w_digit = 2'd2; end
      4'b1000: begin w_valid = 1'b1; w_digit = 2'd3; end
      default: begin w_valid = 1'b0; w_digit = 2'd0; end
    endcase
  end

  always_comb begin
    w_code_dig  = 2'd0;
    w_shadow_wr = r_shadow;
    for (int i = 0; i < DIGITS; i++) begin
      if (3'(i) == r_cnt) begin
        w_code_dig          = r_code[2*i +: 2];
        w_shadow_wr[2*i +: 2] = w_digit;
      end
    end
  end

  assign w_mis_acc = r_mis | ~w_valid | (w_digit != w_code_dig);

  always_comb begin
    w_state_n  = r_state;
    w_code_n   = r_code;
    w_shadow_n = r_shadow;
    w_fail_n   = r_fail;
    w_cnt_n    = r_cnt;
    w_mis_n    = r_mis;
    w_lcnt_n   = r_lcnt;

    unique case (r_state)
      S_IDLE: begin
        if (w_press) begin
          if (w_last) begin
            w_cnt_n = 3'd0;
            w_mis_n = 1'b0;
            if (!w_mis_acc) begin
              w_state_n = S_OPEN;
              w_fail_n  = 4'd0;
            end else begin
              w_fail_n = w_fail_inc;
              if (w_fail_inc == FAIL_LIM) begin
                w_state_n = S_LOCKOUT;
                w_lcnt_n  = LOCK_LD;
              end
            end
          end else begin
            w_cnt_n = r_cnt + 3'd1;
            w_mis_n = w_mis_acc;
          end
        end
      end

      S_OPEN: begin
        if (Lock) begin
          w_state_n = S_IDLE;
          w_cnt_n   = 3'd0;
          w_mis_n   = 1'b0;
        end else if (Set) begin
          w_state_n = S_PROG;
          w_cnt_n   = 3'd0;
        end
      end

      S_PROG: begin
        if (Lock) begin
          w_state_n = S_IDLE;
          w_cnt_n   = 3'd0;
          w_mis_n   = 1'b0;
        end else if (w_valid) begin
          w_shadow_n = w_shadow_wr;
          if (w_last) begin
            w_code_n  = w_shadow_wr;
            w_state_n = S_OPEN;
            w_cnt_n   = 3'd0;
          end else begin
            w_cnt_n = r_cnt + 3'd1;
          end
        end
      end

      S_LOCKOUT: begin
        if (r_lcnt == 16'd0) begin
          w_state_n = S_IDLE;
          w_fail_n  = 4'd0;
          w_cnt_n   = 3'd0;
          w_mis_n   = 1'b0;
        end else begin
          w_lcnt_n = r_lcnt - 16'd1;
        end
      end

      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      r_state  <= S_IDLE;
      r_code   <= DEFAULT_CODE;
      r_shadow <= '0;
      r_fail   <= 4'd0;
      r_cnt    <= 3'd0;
      r_mis    <= 1'b0;
      r_lcnt   <= 16'd0;
    end else begin
      r_state  <= w_state_n;
      r_code   <= w_code_n;
      r_shadow <= w_shadow_n;
      r_fail   <= w_fail_n;
      r_cnt    <= w_cnt_n;
      r_mis    <= w_mis_n;
      r_lcnt   <= w_lcnt_n;
    end
  end

  assign Unlocked = (r_state == S_OPEN);
  assign Prog     = (r_state == S_PROG);
  assign Alarm    = (r_state == S_LOCKOUT);
  assign Count    = r_cnt;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// tb_combo_lock_ctrl: directed and randomized checks of combo_lock_ctrl
// against a queue-based behavioural model of the lock.
module tb_combo_lock_ctrl;

  localparam int DIGITS      = 4;
  localparam int MAX_FAIL    = 3;
  localparam int LOCK_CYCLES = 16;

  localparam int M_IDLE = 0;
  localparam int M_OPEN = 1;
  localparam int M_PROG = 2;
  localparam int M_LOCK = 3;

  logic       Clk = 1'b0;
  logic       Resetn = 1'b1;
  logic [3:0] Btn = 4'd0;
  logic       Set = 1'b0;
  logic       Lock = 1'b0;
  logic       Unlocked;
  logic       Prog;
  logic       Alarm;
  logic [2:0] Count;

  int n_tests = 0;
  int n_fail  = 0;

  int m_mode;
  int m_code[DIGITS];
  int m_entry[$];
  int m_prog[$];
  int m_fails;
  int m_left;

  combo_lock_ctrl dut (
    .Clk(Clk), .Resetn(Resetn), .Btn(Btn), .Set(Set), .Lock(Lock),
    .Unlocked(Unlocked), .Prog(Prog), .Alarm(Alarm), .Count(Count)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic [3:0] oh(input int d);
    return 4'(1 << d);
  endfunction

  function automatic int decode(input logic [3:0] b);
    case (b)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [5:0] exp_out();
    int c;
    c = (m_mode == M_IDLE) ? m_entry.size() :
        (m_mode == M_PROG) ? m_prog.size() : 0;
    return {m_mode == M_OPEN, m_mode == M_PROG, m_mode == M_LOCK, 3'(c)};
  endfunction

  task automatic model_step(input logic [3:0] b, input logic s, l, r);
    int d;
    bit ok;
    d = decode(b);
    if (!r) begin
      m_mode = M_IDLE;
      for (int i = 0; i < DIGITS; i++) m_code[i] = i;
      m_entry.delete();
      m_prog.delete();
      m_fails = 0;
      m_left = 0;
      return;
    end
    case (m_mode)
      M_LOCK: begin
        if (m_left == 0) begin
          m_mode = M_IDLE;
          m_fails = 0;
          m_entry.delete();
        end else m_left--;
      end
      M_OPEN: begin
        if (l) m_mode = M_IDLE;
        else if (s) begin m_mode = M_PROG; m_prog.delete(); end
      end
      M_PROG: begin
        if (l) m_mode = M_IDLE;
        else if (d >= 0) begin
          m_prog.push_back(d);
          if (m_prog.size() == DIGITS) begin
            for (int i = 0; i < DIGITS; i++) m_code[i] = m_prog[i];
            m_prog.delete();
            m_mode = M_OPEN;
          end
        end
      end
      default: begin
        if (b != 4'd0) begin
          m_entry.push_back(d);
          if (m_entry.size() == DIGITS) begin
            ok = 1;
            for (int i = 0; i < DIGITS; i++)
              if (m_entry[i] != m_code[i]) ok = 0;
            m_entry.delete();
            if (ok) begin m_mode = M_OPEN; m_fails = 0; end
            else begin
              m_fails++;
              if (m_fails == MAX_FAIL) begin
                m_mode = M_LOCK;
                m_left = LOCK_CYCLES - 1;
              end
            end
          end
        end
      end
    endcase
  endtask

  task automatic drive(input logic [3:0] b, input logic s, l, r);
    @(negedge Clk);
    Btn = b; Set = s; Lock = l; Resetn = r;
    model_step(b, s, l, r);
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(4'd0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if ({Unlocked, Prog, Alarm, Count} !== 6'd0) begin
        n_fail++;
        $display("FAIL reset got=%b exp=%b", {Unlocked, Prog, Alarm, Count}, 6'd0);
      end
    end
  endtask

  task automatic test_unlock();
    for (int i = 0; i < DIGITS; i++) begin
      drive(oh(i), 1'b0, 1'b0, 1'b1);
      n_tests++;
      if ({Unlocked, Prog, Alarm, Count} !== exp_out()) begin
        n_fail++;
        $display("FAIL unlock_step%0d got=%b exp=%b", i, {Unlocked, Prog, Alarm, Count}, exp_out());
      end
    end
    n_tests++;
    if (Unlocked !== 1'b1 || Count !== 3'd0) begin
      n_fail++;
      $display("FAIL unlock_open got=%b/%0d exp=1/0", Unlocked, Count);
    end
    drive(4'd0, 1'b0, 1'b1, 1'b1);
    n_tests++;
    if (Unlocked !== 1'b0) begin
      n_fail++;
      $display("FAIL unlock_relock got=%b exp=0", Unlocked);
    end
  endtask

  task automatic test_lockout();
    int wrong[DIGITS] = '{0, 1, 2, 2};
    int alarm_cnt = 0;
    for (int e = 0; e < MAX_FAIL; e++)
      for (int i = 0; i < DIGITS; i++) begin
        drive(oh(wrong[i]), 1'b0, 1'b0, 1'b1);
        n_tests++;
        if ({Unlocked, Prog, Alarm, Count} !== exp_out()) begin
          n_fail++;
          $display("FAIL lockout_entry%0d_%0d got=%b exp=%b", e, i, {Unlocked, Prog, Alarm, Count}, exp_out());
        end
      end
    alarm_cnt = Alarm ? 1 : 0;
    for (int k = 0; k < LOCK_CYCLES + 4; k++) begin
      if (m_mode == M_LOCK)
        drive(4'($urandom_range(15)), 1'($urandom), 1'($urandom), 1'b1);
      else
        drive(4'd0, 1'b0, 1'b0, 1'b1);
      n_tests++;
      if ({Unlocked, Prog, Alarm, Count} !== exp_out()) begin
        n_fail++;
        $display("FAIL lockout_wait%0d got=%b exp=%b", k, {Unlocked, Prog, Alarm, Count}, exp_out());
      end
      if (Alarm) alarm_cnt++;
    end
    n_tests++;
    if (alarm_cnt != LOCK_CYCLES) begin
      n_fail++;
      $display("FAIL lockout_len got=%0d exp=%0d", alarm_cnt, LOCK_CYCLES);
    end
    for (int i = 0; i < DIGITS; i++) drive(oh(i), 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (Unlocked !== 1'b1) begin
      n_fail++;
      $display("FAIL lockout_after got=%b exp=1", Unlocked);
    end
    drive(4'd0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_invalid_press();
    logic [3:0] seq[DIGITS] = '{4'b0001, 4'b0011, 4'b0100, 4'b1000};
    for (int i = 0; i < DIGITS; i++) begin
      drive(seq[i], 1'b0, 1'b0, 1'b1);
      n_tests++;
      if ({Unlocked, Prog, Alarm, Count} !== exp_out()) begin
        n_fail++;
        $display("FAIL invalid_step%0d got=%b exp=%b", i, {Unlocked, Prog, Alarm, Count}, exp_out());
      end
    end
    n_tests++;
    if (Unlocked !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_nounlock got=%b exp=0", Unlocked);
    end
    for (int e = 0; e < MAX_FAIL - 1; e++) begin
      drive(oh(0), 1'b0, 1'b0, 1'b1);
      drive(oh(1), 1'b0, 1'b0, 1'b1);
      drive(oh(2), 1'b0, 1'b0, 1'b1);
      drive(oh(2), 1'b0, 1'b0, 1'b1);
    end
    n_tests++;
    if (Alarm !== 1'b1) begin
      n_fail++;
      $display("FAIL invalid_failcount got=%b exp=1", Alarm);
    end
    for (int k = 0; k < LOCK_CYCLES; k++) drive(4'd0, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if ({Unlocked, Prog, Alarm, Count} !== exp_out() || Alarm !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_release got=%b exp=%b", {Unlocked, Prog, Alarm, Count}, exp_out());
    end
  endtask

  task automatic test_prog();
    logic [3:0] seq[5] = '{4'b1000, 4'b0110, 4'b0100, 4'b0010, 4'b0001};
    for (int i = 0; i < DIGITS; i++) drive(oh(i), 1'b0, 1'b0, 1'b1);
    drive(4'd0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (Prog !== 1'b1 || {Unlocked, Prog, Alarm, Count} !== exp_out()) begin
        n_fail++;
        $display("FAIL prog_step%0d got=%b exp=%b", i, {Unlocked, Prog, Alarm, Count}, exp_out());
      end
      drive(seq[i], 1'b0, 1'b0, 1'b1);
    end
    n_tests++;
    if (Unlocked !== 1'b1 || Prog !== 1'b0) begin
      n_fail++;
      $display("FAIL prog_commit got=%b%b exp=10", Unlocked, Prog);
    end
    drive(4'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < DIGITS; i++) drive(oh(3 - i), 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (Unlocked !== 1'b1) begin
      n_fail++;
      $display("FAIL prog_newcode got=%b exp=1", Unlocked);
    end
    drive(4'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < DIGITS; i++) drive(oh(i), 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (Unlocked !== 1'b0 || Count !== 3'd0) begin
      n_fail++;
      $display("FAIL prog_oldcode got=%b/%0d exp=0/0", Unlocked, Count);
    end
    drive(4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_set_lock_same();
    for (int i = 0; i < DIGITS; i++) drive(oh(i), 1'b0, 1'b0, 1'b1);
    drive(4'd0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if ({Unlocked, Prog, Alarm, Count} !== 6'd0 || exp_out() !== 6'd0) begin
        n_fail++;
        $display("FAIL setlock%0d got=%b exp=%b", k, {Unlocked, Prog, Alarm, Count}, 6'd0);
      end
      drive(4'd0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    for (int e = 0; e < MAX_FAIL; e++)
      for (int i = 0; i < DIGITS; i++) drive(oh(i == 3 ? 2 : i), 1'b0, 1'b0, 1'b1);
    drive(4'd0, 1'b0, 1'b0, 1'b1);
    drive(4'd0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if ({Unlocked, Prog, Alarm, Count} !== 6'd0) begin
      n_fail++;
      $display("FAIL rst_lockout got=%b exp=%b", {Unlocked, Prog, Alarm, Count}, 6'd0);
    end
    for (int i = 0; i < DIGITS; i++) drive(oh(i), 1'b0, 1'b0, 1'b1);
    drive(4'd0, 1'b1, 1'b0, 1'b1);
    drive(oh(3), 1'b0, 1'b0, 1'b1);
    drive(oh(3), 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (Prog !== 1'b1 || Count !== 3'd2) begin
      n_fail++;
      $display("FAIL rst_progmid got=%b/%0d exp=1/2", Prog, Count);
    end
    drive(4'd0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if ({Unlocked, Prog, Alarm, Count} !== 6'd0) begin
      n_fail++;
      $display("FAIL rst_prog got=%b exp=%b", {Unlocked, Prog, Alarm, Count}, 6'd0);
    end
    for (int i = 0; i < DIGITS; i++) drive(oh(i), 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (Unlocked !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_default got=%b exp=1", Unlocked);
    end
  endtask

  task automatic test_random();
    logic [3:0] b;
    int r;
    for (int k = 0; k < 4000; k++) begin
      r = $urandom_range(99);
      if (r < 45) b = 4'd0;
      else if (r < 75 && m_mode == M_IDLE) b = oh(m_code[m_entry.size()]);
      else if (r < 90) b = oh($urandom_range(3));
      else b = 4'($urandom_range(15));
      drive(b, $urandom_range(99) < 10, $urandom_range(99) < 6,
            $urandom_range(499) != 0);
      n_tests++;
      if ({Unlocked, Prog, Alarm, Count} !== exp_out()) begin
        n_fail++;
        $display("FAIL random%0d got=%b exp=%b", k, {Unlocked, Prog, Alarm, Count}, exp_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_lockout();
    test_invalid_press();
    test_prog();
    test_reset();
    test_set_lock_same();
    test_reset_mid();
    test_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/combo_lock_ctrl.md
COMBO_LOCK_CTRL -- requirements
Module: combo_lock_ctrl

Interface
REQ-001 Parameter DIGITS, default 4: number of presses per code entry (2..8).
REQ-002 Parameter MAX_FAIL, default 3: consecutive wrong entries that trigger lockout (1..15).
REQ-003 Parameter LOCK_CYCLES, default 16: lockout duration in Clk cycles (1..65535).
REQ-004 Parameter DEFAULT_CODE, default {2'd3,2'd2,2'd1,2'd0} (width 2*DIGITS): reset code; digit i occupies bits [2i+1:2i], and digit 0 is entered first.
REQ-005 Clk  input  1  single clock; all state updates on posedge Clk.
REQ-006 Resetn  input  1  synchronous, active-low reset, sampled on posedge Clk.
REQ-007 Btn  input  4  conditioned one-cycle button pulses; Btn[d] high means digit d pressed.
REQ-008 Set  input  1  conditioned pulse; requests code programming.
REQ-009 Lock  input  1  conditioned pulse; relocks the lock.
REQ-010 Unlocked  output  1  high while in state OPEN.
REQ-011 Prog  output  1  high while in state PROG.
REQ-012 Alarm  output  1  high while in state LOCKOUT.
REQ-013 Count  output  3  presses accepted in the current entry (0..DIGITS-1).

Function
REQ-014 The block SHALL implement states IDLE (locked, collecting), OPEN, PROG and LOCKOUT; all outputs SHALL be registered or decoded from registered state only.
REQ-015 A press is any cycle with Btn != 0; it is valid only if exactly one bit is set, and a multi-bit press is invalid.
REQ-016 In IDLE, each press SHALL increment Count and set an internal mismatch flag if the press is invalid or its digit differs from code digit Count.
REQ-017 On the DIGITS-th press in IDLE, including that press's comparison, a match SHALL move to OPEN on the next edge, clear the fail counter, and clear Count and mismatch.
REQ-018 On a mismatching DIGITS-th press, the fail counter SHALL increment and Count/mismatch SHALL clear; if the new fail count equals MAX_FAIL, the state SHALL go to LOCKOUT, otherwise it SHALL stay in IDLE.
REQ-019 Unlock latency: Unlocked SHALL rise on the cycle after the edge that samples the final correct press.
REQ-020 In LOCKOUT, a down-counter SHALL be loaded with LOCK_CYCLES-1 on entry; Btn, Set and Lock SHALL be ignored; at 0 the state SHALL return to IDLE with the fail counter, Count and mismatch cleared, so Alarm is high for exactly LOCK_CYCLES cycles.
REQ-021 In OPEN, a Lock pulse SHALL go to IDLE; a Set pulse without Lock SHALL go to PROG with Count cleared; Btn SHALL be ignored.
REQ-022 Lock and Set in the same OPEN cycle: Lock SHALL win and the state SHALL go to IDLE.
REQ-023 In PROG, each valid press SHALL write its digit into a shadow register at position Count and increment Count; invalid presses SHALL be ignored and not counted.
REQ-024 On the DIGITS-th valid press in PROG, the shadow SHALL be committed to the code register on the same edge, and the state SHALL return to OPEN with Count cleared.
REQ-025 In PROG, a Lock pulse SHALL abort to IDLE without changing the stored code; Set in PROG SHALL be ignored.
REQ-026 Set and Lock in IDLE SHALL be ignored, and any partial entry SHALL continue.
REQ-027 Lock and a press in the same IDLE cycle: the press SHALL be processed normally.

Reset
REQ-028 With Resetn low at a clock edge, the block SHALL enter IDLE with code=DEFAULT_CODE, fail counter=0, Count=0, mismatch=0 and lockout counter=0.
REQ-029 Outputs after reset SHALL be Unlocked=0, Prog=0, Alarm=0, Count=0.
REQ-030 Reset SHALL take effect from any state, including mid-entry, PROG (shadow discarded, code reverts to DEFAULT_CODE) and LOCKOUT (Alarm drops the cycle after the reset edge).

Verification
REQ-031 Defaults: reset, then Btn pulses 0,1,2,3 -> Count steps 1,2,3,0; Unlocked=1 the cycle after the 4th press; Lock pulse -> Unlocked=0 next cycle.
REQ-032 Wrong entry 0,1,2,2 three times -> Alarm=1 after the third entry for exactly 16 cycles; presses during Alarm have no effect; afterwards 0,1,2,3 unlocks.
REQ-033 Btn=4'b0011 as the 2nd press of 0,(0011),2,3 -> no unlock; fail counter=1 (observe: two more wrong entries give Alarm).
REQ-034 Unlock, Set, presses 3,(0110),2,1,0 -> Prog=1 throughout, invalid press ignored, OPEN after the 4th valid press; Lock; entry 3,2,1,0 unlocks and 0,1,2,3 fails.
REQ-035 Unlock, then Set and Lock in the same cycle -> IDLE, Prog never asserts.
REQ-036 Resetn low during LOCKOUT and during PROG after 2 digits -> IDLE, all outputs 0, and DEFAULT_CODE 0,1,2,3 unlocks.
